qoi_dec_ctrl: RTL and testbench
===============================

// Module: qoi_dec_ctrl
// PURPOSE
//   Chunk-level sequencer for the QOI decoder. Consumes the post-header byte stream and classifies
//   each tag byte into an op_t command. It collects the operand bytes, then issues one command per
//   output pixel (a RUN expands to N commands) to the pixel datapath, which holds the index table
//   and previous pixel. Counts pixels against the image size, then checks the 8-byte end marker.
// PARAMETERS
//   CHECK_TRAILER  1  1: consume and check end marker 00x7,01 after last pixel; 0: go to DONE directly
// PORTS
//   clk          in   1   clock
//   rst_n        in   1   async active-low reset
//   start        in   1   pulse; begin a new image (ignored unless in IDLE or DONE)
//   num_pixels   in   30  size_t, width*height; sampled on accepted start
//   in_data      in   8   byte stream data
//   in_valid     in   1   byte valid
//   in_ready     out  1   byte accepted when in_valid & in_ready
//   cmd_valid    out  1   command to pixel datapath valid
//   cmd_ready    in   1   datapath accepts command
//   cmd_op       out  6   op_t one-hot op (OP_RGB..OP_RUN)
//   cmd_tag      out  8   tag byte (INDEX/DIFF/LUMA/RUN fields decoded downstream)
//   cmd_arg      out  32  operand bytes; arg[7:0]=1st byte after tag, [15:8]=2nd ...; unused=0
//   busy         out  1   high in every state except IDLE/DONE
//   done         out  1   1-cycle pulse on entering DONE
//   err          out  1   sticky; cleared by accepted start
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=0, cmd_valid=0, cmd_op=0, cmd_tag=0, cmd_arg=0, busy=0, done=0, err=0.
//   States: IDLE, TAG, ARGS, ISSUE, RUN, TRAILER, DONE.
//   IDLE/DONE --start--> TAG, with remaining=num_pixels and err=0. If num_pixels==0, go to TRAILER
//     instead (or DONE if CHECK_TRAILER=0).
//   TAG: in_ready=1. Decode the accepted byte. 8'hfe and 8'hff are checked BEFORE the 2-bit mask:
//     fe -> RGB, 3 args; ff -> RGBA, 4 args; (b&QOI_MASK_2)==00 -> INDEX, 0 args; 40 -> DIFF, 0 args;
//     80 -> LUMA, 1 arg; c0 -> RUN, with len=b[5:0]+1 (range 1..62).
//     Register the tag. Clear cmd_arg. Go to ARGS if args>0, RUN if RUN, else ISSUE.
//   ARGS: in_ready=1. Each accepted byte is placed at cmd_arg[8*k+:8] (k=0..). After the last arg, go to ISSUE.
//   ISSUE: in_ready=0, cmd_valid=1. Outputs are held stable until cmd_ready. On handshake,
//     remaining-=1. Next state is TAG if remaining!=0, else TRAILER/DONE.
//   RUN: cmd_valid=1 with cmd_op=OP_RUN. Each handshake decrements both len and remaining.
//     When len reaches 0, go to TAG. When remaining reaches 0 first, go to TRAILER/DONE.
//     If len was still >0 in that case, the extra pixels are dropped and err=1.
//   TRAILER: in_ready=1. Accept exactly 8 bytes and compare them with 00,00,00,00,00,00,00,01.
//     Any mismatch sets err=1. All 8 bytes are still consumed, then go to DONE.
//   DONE: done pulses in the entry cycle. Remain in DONE until start.
//   Latency: a 0-arg tag accepted in cycle N gives cmd_valid in N+1. An RGB tag accepted in N,
//     with args in N+1..N+3 back-to-back, gives cmd_valid in N+4.
//   Max throughput is 1 command/cycle in RUN while cmd_ready=1. In ISSUE it is 1 command per 2 cycles.
//   in_ready and cmd_valid are never high in the same cycle. No combinational path from cmd_ready
//     to in_ready; both come from registered state.
//   in_valid low in TAG/ARGS/TRAILER: wait, no state change. cmd_ready low: hold and wait.
//   start while busy: ignored. Reset mid-image: async return to IDLE, all outputs at reset values.
//   remaining is a 30-bit down-counter; it never wraps below 0.
// TESTING
//   1 Reset, then start with num_pixels=1. Bytes fe,11,22,33, then the trailer -> one cmd: op=OP_RGB,
//     tag=fe, arg=32'h00332211. done pulses, err=0.
//   2 num_pixels=5. Bytes c4 (len 5), then trailer, cmd_ready=1 -> 5 back-to-back OP_RUN cmds,
//     tag=c4 each. Then DONE.
//   3 num_pixels=3. Bytes 05,47,9a,3c -> INDEX (tag 05), DIFF (tag 47), LUMA (tag 9a, arg=32'h3c).
//     Also checks that fe/ff are not decoded as RUN.
//   4 num_pixels=2. Byte c9 (len 10) -> only 2 RUN cmds. err=1 after the run. Trailer consumed. DONE.
//   5 Corrupt trailer (last byte 00) -> err=1, done still pulses. Then start again -> err clears.
//   6 Random stalls on in_valid and cmd_ready, 4 args ff,01,02,03,04 -> arg=32'h04030201, held
//     stable through stalls. rst_n low mid-ARGS -> IDLE with all outputs 0.

Source files
------------

// File: rtl/qoi_dec_ctrl_if.sv
// Purpose: byte-in / command-out bundle around the QOI chunk sequencer.
// Latency: wires only, no state.
// Backpressure: in_valid/in_ready on the byte side, cmd_valid/cmd_ready on the command side.
//
// master: sequencer side (accepts bytes, issues commands)
// slave : environment side (supplies bytes, consumes commands)
interface qoi_dec_ctrl_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_op;
  logic [7:0]  cmd_tag;
  logic [31:0] cmd_arg;

  modport master (
    input  in_data, in_valid, cmd_ready,
    output in_ready, cmd_valid, cmd_op, cmd_tag, cmd_arg
  );

  modport slave (
    output in_data, in_valid, cmd_ready,
    input  in_ready, cmd_valid, cmd_op, cmd_tag, cmd_arg
  );
endinterface

// File: rtl/qoi_dec_ctrl.sv
// Purpose: QOI chunk sequencer; classifies tag bytes, gathers operands, issues one command per pixel.
// Latency: 0-arg tag accepted in N -> cmd_valid in N+1; RGB tag + 3 back-to-back args -> N+4.
// Backpressure: in_ready and cmd_valid are pure state decodes; cmd_ready low holds the command.
//
// Ports: clk, rst_n (async active-low); start/num_pixels begin an image;
//        bus (master): byte stream in, command stream out; busy/done/err status.
module qoi_dec_ctrl #(
  parameter bit CHECK_TRAILER = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [29:0]    num_pixels,
  qoi_dec_ctrl_if.master bus,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam logic [5:0] OP_RGB   = 6'b000001;
  localparam logic [5:0] OP_RGBA  = 6'b000010;
  localparam logic [5:0] OP_INDEX = 6'b000100;
  localparam logic [5:0] OP_DIFF  = 6'b001000;
  localparam logic [5:0] OP_LUMA  = 6'b010000;
  localparam logic [5:0] OP_RUN   = 6'b100000;

  localparam logic [7:0] QOI_OP_RGB   = 8'hfe;
  localparam logic [7:0] QOI_OP_RGBA  = 8'hff;
  localparam logic [7:0] QOI_MASK_2   = 8'hc0;
  localparam logic [7:0] QOI_OP_INDEX = 8'h00;
  localparam logic [7:0] QOI_OP_DIFF  = 8'h40;
  localparam logic [7:0] QOI_OP_LUMA  = 8'h80;

  typedef enum logic [2:0] {IDLE, TAG, ARGS, ISSUE, RUN, TRAILER, DONE} state_t;

  // Where the pixel count lands once the last pixel has been issued.
  localparam state_t END_ST = CHECK_TRAILER ? TRAILER : DONE;

  state_t      state, state_nxt;
  logic        enter_done;
  logic [29:0] remaining;
  logic [5:0]  run_len;
  logic [2:0]  nargs;
  logic [1:0]  arg_idx;
  logic [2:0]  trl_cnt;
  logic [5:0]  cmd_op_q;
  logic [7:0]  cmd_tag_q;
  logic [31:0] cmd_arg_q;

  logic [5:0]  dec_op;
  logic [2:0]  dec_nargs;
  logic [5:0]  dec_len;

  assign bus.in_ready  = (state == TAG) || (state == ARGS) || (state == TRAILER);
  assign bus.cmd_valid = (state == ISSUE) || (state == RUN);
  assign bus.cmd_op    = cmd_op_q;
  assign bus.cmd_tag   = cmd_tag_q;
  assign bus.cmd_arg   = cmd_arg_q;
  assign busy          = (state != IDLE) && (state != DONE);

  // Tag classification. The 8-bit RGB/RGBA tags alias the RUN 2-bit pattern,
  // so they must be matched first. fe/ff excluded keeps dec_len within 1..62.
  always_comb begin
    dec_op    = OP_INDEX;
    dec_nargs = 3'd0;
    dec_len   = bus.in_data[5:0] + 6'd1;
    if (bus.in_data == QOI_OP_RGB) begin
      dec_op    = OP_RGB;
      dec_nargs = 3'd3;
    end else if (bus.in_data == QOI_OP_RGBA) begin
      dec_op    = OP_RGBA;
      dec_nargs = 3'd4;
    end else begin
      case (bus.in_data & QOI_MASK_2)
        QOI_OP_INDEX: dec_op = OP_INDEX;
        QOI_OP_DIFF:  dec_op = OP_DIFF;
        QOI_OP_LUMA: begin
          dec_op    = OP_LUMA;
          dec_nargs = 3'd1;
        end
        default:      dec_op = OP_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    enter_done = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt  = (num_pixels == 30'd0) ? END_ST : TAG;
          enter_done = (num_pixels == 30'd0) && (END_ST == DONE);
        end
      end
      TAG: begin
        if (bus.in_valid) begin
          if (dec_op == OP_RUN)        state_nxt = RUN;
          else if (dec_nargs != 3'd0)  state_nxt = ARGS;
          else                         state_nxt = ISSUE;
        end
      end
      ARGS: begin
        if (bus.in_valid && ({1'b0, arg_idx} == nargs - 3'd1)) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (bus.cmd_ready) state_nxt = (remaining <= 30'd1) ? END_ST : TAG;
      end
      RUN: begin
        // Image end wins over run end; a longer run is truncated.
        if (bus.cmd_ready) begin
          if (remaining <= 30'd1)  state_nxt = END_ST;
          else if (run_len == 6'd1) state_nxt = TAG;
        end
      end
      TRAILER: begin
        if (bus.in_valid && (trl_cnt == 3'd7)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if ((state != IDLE) && (state != DONE) && (state_nxt == DONE)) enter_done = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      run_len   <= '0;
      nargs     <= '0;
      arg_idx   <= '0;
      trl_cnt   <= '0;
      cmd_op_q  <= '0;
      cmd_tag_q <= '0;
      cmd_arg_q <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= enter_done;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            remaining <= num_pixels;
            err       <= 1'b0;
            trl_cnt   <= '0;
          end
        end
        TAG: begin
          if (bus.in_valid) begin
            cmd_op_q  <= dec_op;
            cmd_tag_q <= bus.in_data;
            cmd_arg_q <= '0;
            nargs     <= dec_nargs;
            arg_idx   <= '0;
            run_len   <= dec_len;
          end
        end
        ARGS: begin
          if (bus.in_valid) begin
            cmd_arg_q[{arg_idx, 3'b000} +: 8] <= bus.in_data;
            arg_idx <= arg_idx + 2'd1;
          end
        end
        ISSUE: begin
          if (bus.cmd_ready && (remaining != 30'd0)) remaining <= remaining - 30'd1;
        end
        RUN: begin
          if (bus.cmd_ready) begin
            if (remaining != 30'd0) remaining <= remaining - 30'd1;
            run_len <= run_len - 6'd1;
            if ((remaining <= 30'd1) && (run_len != 6'd1)) err <= 1'b1;
          end
        end
        TRAILER: begin
          // End marker is seven 0x00 bytes followed by 0x01.
          if (bus.in_valid) begin
            trl_cnt <= trl_cnt + 3'd1;
            if (bus.in_data != ((trl_cnt == 3'd7) ? 8'h01 : 8'h00)) err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qoi_dec_ctrl.sv
module tb_qoi_dec_ctrl;

  localparam logic [5:0] T_RGB   = 6'b000001;
  localparam logic [5:0] T_RGBA  = 6'b000010;
  localparam logic [5:0] T_INDEX = 6'b000100;
  localparam logic [5:0] T_DIFF  = 6'b001000;
  localparam logic [5:0] T_LUMA  = 6'b010000;
  localparam logic [5:0] T_RUN   = 6'b100000;

  typedef struct {
    logic [5:0]  op;
    logic [7:0]  tag;
    logic [31:0] arg;
    int          cyc;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [29:0] num_pixels = '0;
  logic        busy, done, err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int overlap  = 0;
  int unstable = 0;
  bit stall_en = 1'b0;
  bit gaps     = 1'b0;
  bit prev_hold = 1'b0;
  logic [45:0] prev_cmd = '0;
  rec_t cq[$];

  qoi_dec_ctrl_if bus ();

  qoi_dec_ctrl #(.CHECK_TRAILER(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_pixels (num_pixels),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Sole driver of cmd_ready; changes just after each rising edge.
  always @(posedge clk) begin
    #1;
    bus.cmd_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Command capture and protocol watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.in_ready && bus.cmd_valid) overlap++;
    if (bus.cmd_valid && bus.cmd_ready)
      cq.push_back('{bus.cmd_op, bus.cmd_tag, bus.cmd_arg, cyc});
    if (prev_hold && bus.cmd_valid && ({bus.cmd_op, bus.cmd_tag, bus.cmd_arg} != prev_cmd))
      unstable++;
    prev_hold = bus.cmd_valid && !bus.cmd_ready;
    prev_cmd  = {bus.cmd_op, bus.cmd_tag, bus.cmd_arg};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [29:0] n);
    start      = 1'b1;
    num_pixels = n;
    tick();
    start      = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    if (gaps) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    if (!ok) chk("in_ready_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic run_trailer(input bit bad);
    for (int k = 0; k < 8; k++)
      send_byte((k == 7) ? (bad ? 8'h00 : 8'h01) : 8'h00);
  endtask

  task automatic wait_cmds(input int n);
    int k;
    k = 0;
    while (cq.size() < n && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("cmd_count", cq.size(), n);
  endtask

  initial begin
    logic [5:0]  e_op  [3];
    logic [7:0]  e_tag [3];
    logic [31:0] e_arg [3];

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_cmd_op", bus.cmd_op, 0);
    chk("rst_cmd_tag", bus.cmd_tag, 0);
    chk("rst_cmd_arg", bus.cmd_arg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single RGB pixel
    cq.delete();
    do_start(30'd1);
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_in_ready_tag", bus.in_ready, 1);
    tick();
    send_byte(8'hfe);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge clk);
    chk("t1_cmd_valid_lat", bus.cmd_valid, 1);
    chk("t1_in_ready_issue", bus.in_ready, 0);
    chk("t1_op", bus.cmd_op, T_RGB);
    chk("t1_tag", bus.cmd_tag, 8'hfe);
    chk("t1_arg", bus.cmd_arg, 32'h00332211);
    tick();
    run_trailer(1'b0);
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_err", err, 0);
    chk("t1_busy_end", busy, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    #1;
    chk("t1_ncmd", cq.size(), 1);

    // 2: RUN of 5 covering the whole image; start while busy is ignored
    cq.delete();
    tick();
    do_start(30'd5);
    do_start(30'd9);
    send_byte(8'hc4);
    wait_cmds(5);
    for (int k = 0; k < 5; k++) begin
      if (k < cq.size()) begin
        chk("t2_op", cq[k].op, T_RUN);
        chk("t2_tag", cq[k].tag, 8'hc4);
      end
    end
    if (cq.size() >= 5) chk("t2_back_to_back", cq[4].cyc - cq[0].cyc, 4);
    @(negedge clk);
    chk("t2_in_ready_trl", bus.in_ready, 1);
    chk("t2_err", err, 0);
    tick();
    run_trailer(1'b0);
    @(negedge clk);
    chk("t2_done", done, 1);
    #1;
    chk("t2_ncmd", cq.size(), 5);

    // 3: INDEX, DIFF, LUMA
    cq.delete();
    tick();
    do_start(30'd3);
    send_byte(8'h05);
    @(negedge clk);
    chk("t3_index_lat", bus.cmd_valid, 1);
    tick();
    send_byte(8'h47);
    send_byte(8'h9a);
    send_byte(8'h3c);
    wait_cmds(3);
    e_op  = '{T_INDEX, T_DIFF, T_LUMA};
    e_tag = '{8'h05, 8'h47, 8'h9a};
    e_arg = '{32'h0, 32'h0, 32'h3c};
    for (int k = 0; k < 3; k++) begin
      if (k < cq.size()) begin
        chk("t3_op", cq[k].op, e_op[k]);
        chk("t3_tag", cq[k].tag, e_tag[k]);
        chk("t3_arg", cq[k].arg, e_arg[k]);
      end
    end
    tick();
    run_trailer(1'b0);
    @(negedge clk);
    chk("t3_done", done, 1);
    chk("t3_err", err, 0);

    // 4: RUN of 10 truncated to 2 pixels
    cq.delete();
    tick();
    do_start(30'd2);
    send_byte(8'hc9);
    wait_cmds(2);
    if (cq.size() >= 2) chk("t4_tag", cq[1].tag, 8'hc9);
    @(negedge clk);
    chk("t4_err", err, 1);
    chk("t4_in_ready_trl", bus.in_ready, 1);
    tick();
    run_trailer(1'b0);
    @(negedge clk);
    chk("t4_done", done, 1);
    chk("t4_err_sticky", err, 1);
    #1;
    chk("t4_ncmd", cq.size(), 2);

    // 5: corrupt trailer, then restart clears err
    tick();
    do_start(30'd1);
    chk("t5_err_cleared", err, 0);
    send_byte(8'h05);
    run_trailer(1'b1);
    @(negedge clk);
    chk("t5_done_bad", done, 1);
    chk("t5_err_bad", err, 1);
    tick();
    do_start(30'd1);
    @(negedge clk);
    chk("t5_err_restart", err, 0);
    tick();
    send_byte(8'h40);
    run_trailer(1'b0);
    @(negedge clk);
    chk("t5_done_good", done, 1);
    chk("t5_err_good", err, 0);

    // 6: RGBA with random stalls on both sides
    cq.delete();
    stall_en = 1'b1;
    gaps     = 1'b1;
    tick();
    do_start(30'd1);
    send_byte(8'hff);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    wait_cmds(1);
    if (cq.size() >= 1) begin
      chk("t6_op", cq[0].op, T_RGBA);
      chk("t6_tag", cq[0].tag, 8'hff);
      chk("t6_arg", cq[0].arg, 32'h04030201);
    end
    tick();
    run_trailer(1'b0);
    @(negedge clk);
    chk("t6_done", done, 1);
    chk("t6_err", err, 0);
    chk("t6_stable", unstable, 0);

    // Reset in the middle of ARGS
    stall_en = 1'b0;
    gaps     = 1'b0;
    tick();
    do_start(30'd1);
    send_byte(8'hff);
    send_byte(8'h01);
    send_byte(8'h02);
    @(negedge clk);
    chk("t6_mid_args_arg", bus.cmd_arg, 32'h00000201);
    chk("t6_mid_args_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_in_ready", bus.in_ready, 0);
    chk("t6_rst_cmd_valid", bus.cmd_valid, 0);
    chk("t6_rst_cmd_op", bus.cmd_op, 0);
    chk("t6_rst_cmd_tag", bus.cmd_tag, 0);
    chk("t6_rst_cmd_arg", bus.cmd_arg, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_err", err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("no_ready_valid_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
